// File: rtl/spi_max7219_slave.sv
// spi_max7219_slave: MAX7219-style SPI receiver that decodes 16-bit frames into display registers.
// SPI pins are oversampled in the clk domain; frames commit one cycle after cs rises.
module spi_max7219_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   output logic        dout,
   output logic [63:0] rows,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown,
   output logic        display_test,
   output logic        frame_valid,
   output logic        frame_error
);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;
   state_t state, state_next;
   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic sclk_d, cs_d;
   logic [15:0] shreg;
   logic [4:0] cnt;
   logic sclk_s, mosi_s, cs_s, sclk_rise, cs_rise, cs_fall;
   logic [3:0] addr;
   logic [7:0] data;
   logic [2:0] digit;
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign addr      = shreg[11:8];
   assign data      = shreg[7:0];
   assign digit     = addr[2:0] - 3'd1;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WAIT_IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      case (state)
         WAIT_IDLE: state_next = cs_s ? IDLE : WAIT_IDLE;
         IDLE:      state_next = cs_fall ? SHIFT : IDLE;
         SHIFT:     state_next = cs_rise ? COMMIT : SHIFT;
         COMMIT:    state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg        <= '0;
         cnt          <= '0;
         dout         <= 1'b0;
         rows         <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown     <= 1'b1;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         dout        <= shreg[15];
         if (state == IDLE && cs_fall) begin
            shreg <= '0;
            cnt   <= '0;
         end else if (state == SHIFT && sclk_rise && !cs_rise) begin
            // a coincident cs edge ends the frame, so that sclk edge is dropped
            shreg <= {shreg[14:0], mosi_s};
            cnt   <= (cnt == 5'd17) ? 5'd17 : cnt + 5'd1;
         end
         if (state == COMMIT) begin
            if (cnt == 5'd16) begin
               frame_valid <= 1'b1;
               if (addr >= 4'h1 && addr <= 4'h8) rows[{digit, 3'b000} +: 8] <= data;
               if (addr == 4'h9) decode_mode <= data;
               if (addr == 4'hA) intensity <= data[3:0];
               if (addr == 4'hB) scan_limit <= data[2:0];
               if (addr == 4'hC) shutdown <= ~data[0];
               if (addr == 4'hF) display_test <= data[0];
            end else begin
               frame_error <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/spi_max7219_slave.md
Name: spi_max7219_slave

Overview:
- Receiving end of the 8x8 LED-matrix SPI link: an SPI slave in the `clk` domain that models a MAX7219.
- Captures 16-bit MSB-first frames on `mosi`/`sclk` framed by `cs`, decodes address and data, and holds the display registers.
- Used as a bench model and as an on-chip monitor behind the matrix SPI driver.
- Provides a daisy-chain output.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on `sclk`/`mosi`/`cs` before edge detection (min 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sclk  input  1  SPI clock; asynchronous to `clk`; high and low phases each ≥ SYNC_STAGES+1 `clk` periods
- mosi  input  1  SPI data; sampled on `sclk` rising edge
- cs  input  1  active-low frame select
- dout  output  1  daisy-chain data: bit 15 of the shift register
- rows  output  64  digit registers 1..8; `rows[8k+7:8k]` = digit k+1
- decode_mode  output  8  register 0x9
- intensity  output  4  register 0xA, data[3:0]
- scan_limit  output  3  register 0xB, data[2:0]
- shutdown  output  1  1 = shutdown mode; equals NOT data[0] of register 0xC
- display_test  output  1  register 0xF, data[0]
- frame_valid  output  1  one-cycle pulse when a well-formed frame commits
- frame_error  output  1  one-cycle pulse when a frame ends with bit count ≠ 16

Behaviour:
- Reset values:
  - All outputs 0, except `shutdown` = 1.
  - Shift register 0; bit counter 0; FSM in WAIT_IDLE.
- Synchronisation:
  - `sclk`, `mosi` and `cs` each pass through SYNC_STAGES flops.
  - Edges are detected against one further registered copy.
  - All logic uses only the synchronised copies.
- FSM states:
  - WAIT_IDLE: exit to IDLE when synced `cs` = 1. Prevents a partial frame after reset from being processed.
  - IDLE: on `cs` falling edge, clear the shift register and bit counter, go to SHIFT.
  - SHIFT:
    - On `sclk` rising edge, shift left with `mosi` into bit 0.
    - Bit counter increments and saturates at 17.
    - On `cs` rising edge, go to COMMIT.
  - COMMIT (exactly one cycle), then IDLE:
    - If count = 16: pulse `frame_valid` and write the addressed register in this cycle.
    - Else: pulse `frame_error`; no register changes.
- Frame decode:
  - addr = frame[11:8], data = frame[7:0]; frame[15:12] is ignored.
  - addr 0x1–0x8 → digit addr; 0x9, 0xA, 0xB, 0xC, 0xF as listed under Ports.
  - addr 0x0 (no-op) and 0xD/0xE: `frame_valid` still pulses; no register changes.
- Outputs are registered. New register values and `frame_valid` become visible together, in the cycle after COMMIT is entered.
- Latency: from `cs` rising at the pin to `frame_valid` high is exactly SYNC_STAGES+2 `clk` rising edges.
- `dout` follows shift-register bit 15 one cycle after each shift, and holds its value while `cs` is high.
- Simultaneous synced `sclk` rising edge and `cs` rising edge: the `cs` edge wins and the `sclk` edge is dropped.
- `sclk` edges seen while in IDLE or WAIT_IDLE are ignored.
- `cs` falling edge during COMMIT: ignored. Minimum `cs`-high time is 3 `clk` cycles.
- Async reset mid-frame: all state returns to reset values immediately and the FSM enters WAIT_IDLE. The partial frame is discarded with no `frame_error`.

Test Plan:
- Send 0x0181, then 0x08F0 → one `frame_valid` pulse per frame, SYNC_STAGES+2 cycles after each `cs` rising edge; `rows[7:0]` = 0x81, `rows[63:56]` = 0xF0, all other rows 0.
- Send 0x0A07, 0x0B05, 0x0C01, 0x0F01, 0x09FF → `intensity` = 7, `scan_limit` = 5, `shutdown` = 0, `display_test` = 1, `decode_mode` = 0xFF.
- Send 15-bit frame 0x0155>>1, then a 17-bit frame → two `frame_error` pulses, no `frame_valid`, all registers unchanged.
- Send 0x0012 (no-op) and 0x0D34 → `frame_valid` pulses, registers unchanged; then 0x0C00 → `shutdown` returns to 1.
- Send 0x0381, then stream another 0x0000 without deasserting `cs` → `dout` reproduces 0x0381 MSB-first during the second 16 clocks; `frame_error` on release (count saturated at 17).
- Assert `reset` after 8 bits with `cs` held low, release, finish the clocks, raise `cs` → no `frame_valid` or `frame_error`; next full frame 0x0255 gives `rows[15:8]` = 0x55.
